// File: rtl/ha_acc_pkg.sv
// Shared types and widths for the partial-product row accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ha_acc_pkg;

  localparam int HA_B_W    = 7;
  localparam int HA_T_W    = 9;
  localparam int HA_ROWS   = 4;
  localparam int ACC_W     = 17;
  localparam int PROD_W    = 16;
  localparam int ROW_IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ha_row_weight.sv
// Weights one row's sum (t) and carry (b) vectors into a single accumulator-width value.
// Latency: combinational.
// Backpressure: none.
module ha_row_weight
  import ha_acc_pkg::*;
(
  input  logic [HA_B_W-1:0]    b,
  input  logic [HA_T_W-1:0]    t,
  input  logic [ROW_IDX_W-1:0] row,
  output logic [ACC_W-1:0]     weighted
);

  // Row N sits 2N bits up; carry bits sit a further 2 bits above the sum bits.
  logic [3:0] t_shift;
  logic [3:0] b_shift;

  assign t_shift  = {1'b0, row, 1'b0};
  assign b_shift  = t_shift + 4'd2;
  assign weighted = (ACC_W'(t) << t_shift) + (ACC_W'(b) << b_shift);

endmodule

// File: rtl/ha_array_accum.sv
// Accumulates four weighted sum/carry rows into a saturated 16-bit product (optional bias: HA_ACC_BIAS_EN).
// Latency: out_valid 5 cycles after accept (4 row additions + 1 output register stage).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, one cycle after the handshake.
module ha_array_accum
  import ha_acc_pkg::*;
#(
  parameter logic [15:0] BIAS = 16'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HA_B_W-1:0] ha_array_0_b,
  input  logic [HA_B_W-1:0] ha_array_1_b,
  input  logic [HA_B_W-1:0] ha_array_2_b,
  input  logic [HA_B_W-1:0] ha_array_3_b,
  input  logic [HA_T_W-1:0] ha_array_0_t,
  input  logic [HA_T_W-1:0] ha_array_1_t,
  input  logic [HA_T_W-1:0] ha_array_2_t,
  input  logic [HA_T_W-1:0] ha_array_3_t,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy
);

  state_t state;
  state_t state_next;

  logic [HA_B_W-1:0]    b_hold [HA_ROWS];
  logic [HA_T_W-1:0]    t_hold [HA_ROWS];
  logic [ACC_W-1:0]     acc;
  logic [ROW_IDX_W-1:0] row_idx;
  logic [ACC_W-1:0]     row_val;
  logic [ACC_W:0]       final_sum;
  logic [PROD_W-1:0]    sat_sum;
  logic                 accept;
  logic                 release_out;

  assign in_ready    = (state == IDLE);
  assign busy        = (state == ACC) || (state == DONE);
  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;

  ha_row_weight u_row_weight (
    .b        (b_hold[row_idx]),
    .t        (t_hold[row_idx]),
    .row      (row_idx),
    .weighted (row_val)
  );

  // Final sum ahead of saturation; one extra bit absorbs the bias carry.
`ifdef HA_ACC_BIAS_EN
  assign final_sum = {1'b0, acc} + {2'b00, BIAS};
`else
  logic unused_bias;
  assign unused_bias = ^BIAS;
  assign final_sum   = {1'b0, acc};
`endif

  assign sat_sum = (final_sum[ACC_W:PROD_W] != '0) ? {PROD_W{1'b1}} : final_sum[PROD_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: one row per ACC cycle, DONE waits indefinitely for the consumer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACC;
      ACC:     if (row_idx == ROW_IDX_W'(HA_ROWS - 1)) state_next = DONE;
      DONE:    if (release_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture rows on accept, accumulate in ACC, register the result on DONE entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < HA_ROWS; i++) begin
        b_hold[i] <= '0;
        t_hold[i] <= '0;
      end
      acc       <= '0;
      row_idx   <= '0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            b_hold[0] <= ha_array_0_b;
            b_hold[1] <= ha_array_1_b;
            b_hold[2] <= ha_array_2_b;
            b_hold[3] <= ha_array_3_b;
            t_hold[0] <= ha_array_0_t;
            t_hold[1] <= ha_array_1_t;
            t_hold[2] <= ha_array_2_t;
            t_hold[3] <= ha_array_3_t;
            acc       <= '0;
            row_idx   <= '0;
          end
        end
        ACC: begin
          acc     <= acc + row_val;
          row_idx <= row_idx + 1'b1;
        end
        DONE: begin
          if (!out_valid) begin
            product   <= sat_sum;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_array_accum.sv
// Randomized and directed bench for ha_array_accum against a bit-weight reference model.
// Latency: checks out_valid exactly 5 cycles after each accept.
// Backpressure: holds out_ready low for varying spans and checks the result stays put.
module tb_ha_array_accum;

  localparam logic [15:0] TB_BIAS = 16'd50;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] b_in [4];
  logic [8:0] t_in [4];
  logic       out_valid;
  logic       out_ready;
  logic [15:0] product;
  logic       busy;

  int tests_run;
  int tests_failed;

  ha_array_accum #(.BIAS(TB_BIAS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (b_in[0]),
    .ha_array_1_b (b_in[1]),
    .ha_array_2_b (b_in[2]),
    .ha_array_3_b (b_in[3]),
    .ha_array_0_t (t_in[0]),
    .ha_array_1_t (t_in[1]),
    .ha_array_2_t (t_in[2]),
    .ha_array_3_t (t_in[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: every set bit contributes its positional weight, then optional bias, then clamp.
  function automatic longint model_product();
    longint sum;
    sum = 0;
    for (int n = 0; n < 4; n++) begin
      for (int k = 0; k < 9; k++)
        if (t_in[n][k]) sum += longint'(1) << (k + 2 * n);
      for (int k = 0; k < 7; k++)
        if (b_in[n][k]) sum += longint'(1) << (k + 2 + 2 * n);
    end
`ifdef HA_ACC_BIAS_EN
    sum += TB_BIAS;
`endif
    if (sum > 65535) sum = 65535;
    return sum;
  endfunction

  task automatic clear_rows();
    for (int n = 0; n < 4; n++) begin
      b_in[n] = '0;
      t_in[n] = '0;
    end
  endtask

  task automatic random_rows();
    for (int n = 0; n < 4; n++) begin
      b_in[n] = 7'($urandom);
      t_in[n] = 9'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: present current rows, check latency/result, optionally stall, then release.
  task automatic run_txn(input string tag, input int hold);
    longint exp;
    int     lat;
    int     guard;
    logic [15:0] held;
    exp = model_product();
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk({tag, "_in_ready_pre"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_in_ready_busy"}, in_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      random_rows();
      in_valid = 1'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_product"}, product, 32'(exp));
    held = product;
    for (int i = 0; i < hold; i++) begin
      random_rows();
      in_valid = 1'b1;
      tick();
      chk({tag, "_hold_valid"}, out_valid, 1'b1);
      chk({tag, "_hold_product"}, product, held);
      chk({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_post_valid"}, out_valid, 1'b0);
    chk({tag, "_post_in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    random_rows();
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_product", product, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Single LSB of row 0.
    clear_rows();
    t_in[0] = 9'h001;
    run_txn("row0_t1", 0);
`ifndef HA_ACC_BIAS_EN
    chk("row0_t1_const", product, 16'h0001);
`endif

    // Top carry bit of row 3.
    clear_rows();
    b_in[3] = 7'h40;
    run_txn("row3_b40", 1);
`ifndef HA_ACC_BIAS_EN
    chk("row3_b40_const", product, 16'h4000);
`endif

    // Everything set: saturates.
    for (int n = 0; n < 4; n++) begin
      t_in[n] = 9'h1FF;
      b_in[n] = 7'h7F;
    end
    run_txn("all_ones", 0);
    chk("all_ones_const", product, 16'hFFFF);

    // Long stall with new inputs offered the whole time.
    random_rows();
    run_txn("stall10", 10);

    // Bias case: row0 t=4 gives 54 with bias, 4 without.
    clear_rows();
    t_in[0] = 9'h004;
    run_txn("bias", 0);
`ifdef HA_ACC_BIAS_EN
    chk("bias_const", product, 16'd54);
`else
    chk("bias_const", product, 16'd4);
`endif

    // Reset in the middle of accumulation discards the operation.
    random_rows();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_product", product, 16'h0000);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    clear_rows();
    t_in[1] = 9'h003;
    run_txn("after_rst", 2);

    // Random traffic with random stalls.
    for (int i = 0; i < 30; i++) begin
      random_rows();
      if (i % 5 == 0) begin
        for (int n = 0; n < 4; n++) b_in[n] = '0;
      end
      run_txn("rand", int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
